outport_rr_buffer: RTL

//  Output-port stage placed directly downstream of route computation in the 5-port mesh router.
//  One instance per output direction (E/W/N/S/LOCAL).
//  - Collects flits from all 5 input ports whose computed direction equals MY_DIR.
//  - Arbitrates round-robin and buffers the winner in a small FIFO.
//  - Presents flits to the link (or local sink) with a valid/ready handshake.

---
 rtl/outport_rr_buffer_if.sv | 35 +++
 rtl/outport_rr_buffer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/outport_rr_buffer_if.sv
// Interface: outport_rr_buffer_if
// Bundles the five-port request side and the single output link of one
// router output-port stage. The slave modport is the buffer, and the
// master modport is whatever drives it: route compute plus the link sink.
interface outport_rr_buffer_if #(
    parameter int FW = 10
);
    logic [5*FW-1:0] in_flit;
    logic [14:0]     in_dir;
    logic [4:0]      in_valid;
    logic [4:0]      in_ready;
    logic [FW-1:0]   out_flit;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output in_flit,
        output in_dir,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_flit,
        input  out_valid
    );

    modport slave (
        input  in_flit,
        input  in_dir,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_flit,
        output out_valid
    );
endinterface

// File: rtl/outport_rr_buffer.sv
// Module: outport_rr_buffer
// Output-port stage of the 5-port mesh router. It collects flits whose
// routed direction equals MY_DIR, picks one per cycle round-robin, buffers
// the winner in a DEPTH-entry FIFO and offers the FIFO head on a
// valid/ready link.
// Optional feature: define OUTPORT_STALL_CNT_EN to build a saturating
// counter of link stall cycles. Without it, stall_cnt is a constant zero.
module outport_rr_buffer #(
    parameter logic [2:0] MY_DIR = 3'b000,
    parameter int         DEPTH  = 4,
    parameter int         FW     = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    outport_rr_buffer_if.slave bus,
    output logic [3:0]         fifo_cnt,
    output logic [15:0]        stall_cnt
);

    localparam int         NP      = 5;
    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    // Round-robin index arithmetic over the five ports, modulo 5.
    function automatic logic [2:0] rr_add(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= 4'd5) begin
            sum = sum - 4'd5;
        end
        return sum[2:0];
    endfunction

`ifdef OUTPORT_STALL_CNT_EN
    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    logic [NP-1:0]  req;
    logic [2:0]     rr_ptr;
    logic [2:0]     cand;
    logic [NP-1:0]  grant_p0;
    logic [2:0]     win_p0;
    logic           vld_p0;
    logic [FW-1:0]  flit_p0;

    logic [FW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [3:0]     cnt;
    logic           nonempty;
    logic           pop;

    // Request qualification: only flits routed to this output take part.
    // Direction codes 101..111 can never equal a legal MY_DIR, so they never match.
    always_comb begin
        req = '0;
        for (int i = 0; i < NP; i++) begin
            req[i] = bus.in_valid[i] & (bus.in_dir[i*3 +: 3] == MY_DIR);
        end
    end

    // ---- stage p0: round-robin arbitration, gated by FIFO space ----
    // The search starts at rr_ptr, and the first requester found wins.
    // A full FIFO grants nothing, even when a pop happens in the same cycle.
    always_comb begin
        grant_p0 = '0;
        win_p0   = '0;
        vld_p0   = 1'b0;
        cand     = '0;
        if (cnt < DEPTH_C) begin
            for (int k = 0; k < NP; k++) begin
                cand = rr_add(rr_ptr, 3'(k));
                if (!vld_p0 && req[cand]) begin
                    vld_p0         = 1'b1;
                    win_p0         = cand;
                    grant_p0[cand] = 1'b1;
                end
            end
        end
    end

    assign flit_p0      = bus.in_flit[int'(win_p0)*FW +: FW];
    assign bus.in_ready = grant_p0;

    assign nonempty = (cnt != 4'd0);
    assign pop      = nonempty & bus.out_ready;

    // The pointer moves just past the granted port. With no grant it holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (vld_p0) begin
            rr_ptr <= rr_add(win_p0, 3'd1);
        end
    end

    // ---- stage p1: FIFO storage, visible one cycle after the grant ----
    // The FIFO control is kept apart from the data. Occupancy has its own
    // counter, so full and empty can never be confused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= 4'd0;
        end else begin
            if (vld_p0) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({vld_p0, pop})
                2'b10:   cnt <= cnt + 4'd1;
                2'b01:   cnt <= cnt - 4'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Flit storage carries no reset. The output mask below hides stale contents.
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            mem[wr_ptr] <= flit_p0;
        end
    end

    assign bus.out_valid = nonempty;
    assign bus.out_flit  = nonempty ? mem[rd_ptr] : '0;
    assign fifo_cnt      = cnt;

`ifdef OUTPORT_STALL_CNT_EN
    logic [15:0] stall_q;

    // Count the cycles in which the head flit is offered but the link refuses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'h0000;
        end else if (nonempty && !bus.out_ready) begin
            stall_q <= sat_inc16(stall_q);
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule
